// File: rtl/instruction_loader.sv
// Byte-stream boot loader: packs 4 bytes per word and writes them to instruction memory from address 0.
// Optional LOADER_CHECKSUM_EN treats the word ending the stream as an XOR checksum instead of writing it.
module instruction_loader #(
  parameter int DEPTH      = 256,
  parameter int BIG_ENDIAN = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  input  logic                     byte_last,
  output logic                     byte_ready,
  output logic                     mem_we,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [$clog2(DEPTH):0]   word_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C   = {{(CW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  state_t          state_r;
  state_t          state_nx_s;
  logic [1:0]      idx_r;
  logic [31:0]     asm_r;
  logic            last_r;
  logic [CW-1:0]   count_r;
  logic            hs_s;
  logic            restart_s;
  logic [31:0]     word_s;
  logic            ready_nx_s;
  logic            we_nx_s;
  logic            busy_nx_s;
  logic            done_nx_s;
  logic            error_nx_s;
  logic            ready_r;
  logic            we_r;
  logic            busy_r;
  logic            done_r;
  logic            error_r;
  logic [31:0]     addr_r;
  logic [31:0]     wdata_r;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]     csum_r;
`endif

  // Place a byte into the lane chosen by its position in the word and the byte order.
  function automatic logic [31:0] insert_byte(input logic [31:0] w, input logic [1:0] idx,
                                              input logic [7:0] b);
    logic [1:0]  lane;
    logic [31:0] r;
    lane = (BIG_ENDIAN != 0) ? (2'd3 - idx) : idx;
    r = w;
    r[{lane, 3'b000} +: 8] = b;
    return r;
  endfunction

  assign hs_s      = (state_r == S_LOAD) && byte_valid;
  assign restart_s = start && ((state_r == S_IDLE) || (state_r == S_DONE) || (state_r == S_ERROR));
  assign word_s    = insert_byte(asm_r, idx_r, byte_data);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decision, including truncation, overflow and checksum outcomes.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_nx_s = S_LOAD;
        end else begin
          state_nx_s = state_r;
        end
      end
      S_LOAD: begin
        if (hs_s) begin
          if (idx_r == 2'd3) begin
`ifdef LOADER_CHECKSUM_EN
            if (byte_last) begin
              if ((count_r == ZERO_C) || (word_s != csum_r)) begin
                state_nx_s = S_ERROR;
              end else begin
                state_nx_s = S_DONE;
              end
            end else if (count_r == DEPTH_C) begin
              state_nx_s = S_ERROR;
            end else begin
              state_nx_s = S_WRITE;
            end
`else
            if (count_r == DEPTH_C) begin
              state_nx_s = S_ERROR;
            end else begin
              state_nx_s = S_WRITE;
            end
`endif
          end else if (byte_last) begin
            state_nx_s = S_ERROR;
          end else begin
            state_nx_s = S_LOAD;
          end
        end else begin
          state_nx_s = S_LOAD;
        end
      end
      S_WRITE: begin
        if (last_r) begin
          state_nx_s = S_DONE;
        end else begin
          state_nx_s = S_LOAD;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the flags can be registered without added latency.
  always_comb begin
    ready_nx_s = 1'b0;
    we_nx_s    = 1'b0;
    busy_nx_s  = 1'b0;
    done_nx_s  = 1'b0;
    error_nx_s = 1'b0;
    case (state_nx_s)
      S_LOAD: begin
        ready_nx_s = 1'b1;
        busy_nx_s  = 1'b1;
      end
      S_WRITE: begin
        we_nx_s   = 1'b1;
        busy_nx_s = 1'b1;
      end
      S_DONE: begin
        done_nx_s = 1'b1;
      end
      S_ERROR: begin
        error_nx_s = 1'b1;
      end
      default: begin
        ready_nx_s = 1'b0;
      end
    endcase
  end

  // Registered status flags and memory write port; address/data hold between writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_r <= 1'b0;
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      error_r <= 1'b0;
      addr_r  <= 32'h0000_0000;
      wdata_r <= 32'h0000_0000;
    end else begin
      ready_r <= ready_nx_s;
      we_r    <= we_nx_s;
      busy_r  <= busy_nx_s;
      done_r  <= done_nx_s;
      error_r <= error_nx_s;
      if ((state_r == S_LOAD) && (state_nx_s == S_WRITE)) begin
        addr_r  <= 32'({count_r, 2'b00});
        wdata_r <= word_s;
      end
    end
  end

  // Byte index, word assembly and per-session word counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_r   <= 2'd0;
      asm_r   <= 32'h0000_0000;
      last_r  <= 1'b0;
      count_r <= ZERO_C;
    end else if (restart_s) begin
      idx_r   <= 2'd0;
      asm_r   <= 32'h0000_0000;
      last_r  <= 1'b0;
      count_r <= ZERO_C;
    end else if (hs_s) begin
      asm_r  <= word_s;
      idx_r  <= idx_r + 2'd1;
      last_r <= byte_last;
    end else if (state_r == S_WRITE) begin
      idx_r   <= 2'd0;
      count_r <= count_r + ONE_C;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of every word written in the session.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_r <= 32'h0000_0000;
    end else if (restart_s) begin
      csum_r <= 32'h0000_0000;
    end else if (state_r == S_WRITE) begin
      csum_r <= csum_r ^ wdata_r;
    end
  end
`endif

  assign byte_ready = ready_r;
  assign mem_we     = we_r;
  assign mem_addr   = addr_r;
  assign mem_wdata  = wdata_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign word_count = count_r;

endmodule
